// File: rtl/fp_norm_shift.sv
// fp_norm_shift: two-stage normalization between the LOPD tree and rounding.
// S1 clamps the leading-zero count and picks the shift amount, the adjusted
// exponent and the underflow/zero flags. S2 applies the left barrel shift.
// Both stages use a valid/ready handshake and hold their contents under stall.
// Optional feature: define NORM_FTZ_EN to flush tiny results to zero in S2
// instead of producing gradual-underflow (subnormal) results.
module fp_norm_shift #(
   parameter int WIDTH = 24,
   parameter int EXP_W = 8,
   parameter int POS_W = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_mant,
   input  logic [EXP_W-1:0] i_exp,
   input  logic [POS_W-1:0] i_lopd_pos,
   input  logic             i_zero_flag,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_mant,
   output logic [EXP_W-1:0] o_exp,
   output logic             o_underflow,
   output logic             o_zero
);

   localparam logic [POS_W-1:0] LZC_MAX = POS_W'(WIDTH - 1);

   // Logarithmic left shifter: stage k moves the word by 2**k when sh[k] is set.
   function automatic logic [WIDTH-1:0] barrel_shl(input logic [WIDTH-1:0] din,
                                                   input logic [POS_W-1:0] sh);
      logic [WIDTH-1:0] stage;
      stage = din;
      for (int k = 0; k < POS_W; k++) begin
         if (sh[k]) begin
            stage = stage << (32'd1 << k);
         end else begin
            stage = stage;
         end
      end
      return stage;
   endfunction

   // Stage 1 state
   logic             s1_valid_r;
   logic [WIDTH-1:0] s1_mant_r;
   logic [POS_W-1:0] s1_shift_r;
   logic [EXP_W-1:0] s1_exp_r;
   logic             s1_uf_r;
   logic             s1_zero_r;

   // Stage 2 state (drives the outputs directly)
   logic             s2_valid_r;
   logic [WIDTH-1:0] s2_mant_r;
   logic [EXP_W-1:0] s2_exp_r;
   logic             s2_uf_r;
   logic             s2_zero_r;

   // Combinational helpers
   logic             s2_adv_s;
   logic             s1_adv_s;
   logic [POS_W-1:0] lzc_s;
   logic [EXP_W:0]   diff_s;
   logic             diff_pos_s;
   logic [POS_W-1:0] shift_s;
   logic [EXP_W-1:0] nexp_s;
   logic             uf_s;
   logic             zero_s;
   logic [WIDTH-1:0] s2_mant_nx_s;
   logic [EXP_W-1:0] s2_exp_nx_s;
   logic             s2_uf_nx_s;
   logic             s2_zero_nx_s;

   // Pipeline advance: a stage may load when it is empty or its successor moves.
   always_comb begin
      s2_adv_s = !s2_valid_r || i_ready;
      s1_adv_s = !s1_valid_r || s2_adv_s;
   end

   assign o_ready = s1_adv_s;

   // Stage-1 decode: clamp the count, then choose shift/exponent/flags.
   always_comb begin
      lzc_s      = (i_lopd_pos > LZC_MAX) ? LZC_MAX : i_lopd_pos;
      diff_s     = {1'b0, i_exp} - {{(EXP_W + 1 - POS_W){1'b0}}, lzc_s};
      diff_pos_s = !diff_s[EXP_W] && (diff_s != {(EXP_W + 1){1'b0}});
      shift_s    = {POS_W{1'b0}};
      nexp_s     = {EXP_W{1'b0}};
      uf_s       = 1'b0;
      zero_s     = 1'b0;
      if (i_zero_flag) begin
         zero_s = 1'b1;
      end else if (diff_pos_s) begin
         shift_s = lzc_s;
         nexp_s  = diff_s[EXP_W-1:0];
      end else if (i_exp != {EXP_W{1'b0}}) begin
         // Here i_exp <= lzc < WIDTH, so its low bits hold the whole value.
         shift_s = i_exp[POS_W-1:0] - {{(POS_W - 1){1'b0}}, 1'b1};
         uf_s    = 1'b1;
      end else begin
         uf_s = 1'b1;
      end
   end

   // Stage-1 register: capture the decoded beat whenever S1 may advance.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid_r <= 1'b0;
         s1_mant_r  <= {WIDTH{1'b0}};
         s1_shift_r <= {POS_W{1'b0}};
         s1_exp_r   <= {EXP_W{1'b0}};
         s1_uf_r    <= 1'b0;
         s1_zero_r  <= 1'b0;
      end else if (s1_adv_s) begin
         s1_valid_r <= i_valid;
         if (i_valid) begin
            s1_mant_r  <= i_mant;
            s1_shift_r <= shift_s;
            s1_exp_r   <= nexp_s;
            s1_uf_r    <= uf_s;
            s1_zero_r  <= zero_s;
         end
      end
   end

   // Stage-2 datapath: normalize the mantissa, optionally flushing tiny results.
   always_comb begin
      s2_mant_nx_s = barrel_shl(s1_mant_r, s1_shift_r);
      s2_exp_nx_s  = s1_exp_r;
      s2_uf_nx_s   = s1_uf_r;
      s2_zero_nx_s = s1_zero_r;
`ifdef NORM_FTZ_EN
      if (s1_uf_r) begin
         s2_mant_nx_s = {WIDTH{1'b0}};
         s2_exp_nx_s  = {EXP_W{1'b0}};
         s2_zero_nx_s = 1'b1;
      end else begin
         s2_zero_nx_s = s1_zero_r;
      end
`endif
   end

   // Stage-2 register: output beat, held unchanged while downstream stalls.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_valid_r <= 1'b0;
         s2_mant_r  <= {WIDTH{1'b0}};
         s2_exp_r   <= {EXP_W{1'b0}};
         s2_uf_r    <= 1'b0;
         s2_zero_r  <= 1'b0;
      end else if (s2_adv_s) begin
         s2_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            s2_mant_r <= s2_mant_nx_s;
            s2_exp_r  <= s2_exp_nx_s;
            s2_uf_r   <= s2_uf_nx_s;
            s2_zero_r <= s2_zero_nx_s;
         end
      end
   end

   assign o_valid     = s2_valid_r;
   assign o_mant      = s2_mant_r;
   assign o_exp       = s2_exp_r;
   assign o_underflow = s2_uf_r;
   assign o_zero      = s2_zero_r;

endmodule

// File: tb/tb_fp_norm_shift.sv
// Scoreboard bench for fp_norm_shift: the driver pushes expected results when
// a beat is accepted, a monitor pops and compares on every output transfer.
module tb_fp_norm_shift;

   typedef struct packed {
      logic [23:0] m;
      logic [7:0]  e;
      logic        uf;
      logic        z;
   } exp_t;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [23:0] i_mant = 24'd0;
   logic [7:0]  i_exp = 8'd0;
   logic [4:0]  i_lopd_pos = 5'd0;
   logic        i_zero_flag = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic [23:0] o_mant;
   logic [7:0]  o_exp;
   logic        o_underflow;
   logic        o_zero;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_illegal = 0;

   fp_norm_shift dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
      .i_mant(i_mant), .i_exp(i_exp), .i_lopd_pos(i_lopd_pos),
      .i_zero_flag(i_zero_flag), .o_valid(o_valid), .i_ready(i_ready),
      .o_mant(o_mant), .o_exp(o_exp), .o_underflow(o_underflow), .o_zero(o_zero)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference: normalization rules evaluated with plain integer arithmetic.
   function automatic exp_t model(input logic [23:0] m, input logic [7:0] e,
                                  input logic [4:0] p, input logic z);
      exp_t  r;
      int    lzc, diff, sh;
      longint mv;
      lzc  = (int'(p) > 23) ? 23 : int'(p);
      diff = int'(e) - lzc;
      sh   = 0;
      r.e  = 8'd0;
      r.uf = 1'b0;
      r.z  = 1'b0;
      if (z) r.z = 1'b1;
      else if (diff >= 1) begin sh = lzc; r.e = 8'(diff); end
      else if (int'(e) >= 1) begin sh = int'(e) - 1; r.uf = 1'b1; end
      else r.uf = 1'b1;
      mv  = (longint'(m) * (64'sd1 <<< sh)) % (64'sd1 <<< 24);
      r.m = 24'(mv);
`ifdef NORM_FTZ_EN
      if (r.uf) begin r.m = 24'd0; r.e = 8'd0; r.z = 1'b1; end
`endif
      return r;
   endfunction

   function automatic exp_t mk(input logic [23:0] m, input logic [7:0] e, input logic uf, input logic z);
      exp_t r;
      r.m = m; r.e = e; r.uf = uf; r.z = z;
      return r;
   endfunction

   // Monitor: every output transfer must match the oldest expected beat.
   always @(negedge i_clk) begin
      if (!i_rst && o_valid && i_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_beat", 1'b0, 64'({o_mant, o_exp, o_underflow, o_zero}), 64'd0);
         end else begin
            exp_t ex;
            ex = sb.pop_front();
            chk("beat", {o_mant, o_exp, o_underflow, o_zero} == ex,
                64'({o_mant, o_exp, o_underflow, o_zero}), 64'(ex));
         end
      end
   end

   // Offer one beat, wait (bounded) for acceptance, record the expectation.
   task automatic send(input logic [23:0] m, input logic [7:0] e, input logic [4:0] p,
                       input logic z, input exp_t ex, input bit rbp);
      int budget;
      budget = 0;
      i_mant = m; i_exp = e; i_lopd_pos = p; i_zero_flag = z; i_valid = 1'b1;
      @(negedge i_clk);
      while (!o_ready && budget < 200) begin
         @(posedge i_clk);
         #1;
         if (rbp) i_ready = ($urandom_range(0, 3) != 0);
         budget++;
         @(negedge i_clk);
      end
      if (!o_ready) begin
         chk("accept_timeout", 1'b0, 64'd0, 64'd1);
         i_valid = 1'b0;
      end else begin
         @(posedge i_clk);
         sb.push_back(ex);
         #1;
         i_valid = 1'b0;
         if (rbp) i_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      i_ready = 1'b1;
      while (sb.size() != 0 && budget < 50) begin
         @(posedge i_clk);
         budget++;
      end
      chk("drain", sb.size() == 0, 64'(sb.size()), 64'd0);
      repeat (2) @(posedge i_clk);
      #1;
   endtask

   initial begin
      exp_t ex;
      logic [23:0] m, top, hold_m;
      logic [7:0]  e;
      logic [4:0]  p;
      logic        z;
      int          r;

      // Reset state
      #12;
      chk("rst_valid", o_valid == 1'b0, 64'(o_valid), 64'd0);
      chk("rst_outs", {o_mant, o_exp, o_underflow, o_zero} == 34'd0,
          64'({o_mant, o_exp, o_underflow, o_zero}), 64'd0);
      chk("rst_ready", o_ready == 1'b1, 64'(o_ready), 64'd1);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;

      // Directed: normal case, with two-cycle latency check
      send(24'h008000, 8'd100, 5'd8, 1'b0, mk(24'h800000, 8'd92, 1'b0, 1'b0), 1'b0);
      @(negedge i_clk);
      chk("latency_s1", o_valid == 1'b0, 64'(o_valid), 64'd0);
      @(negedge i_clk);
      chk("latency_s2", o_valid == 1'b1, 64'(o_valid), 64'd1);
      @(posedge i_clk);
      #1;

`ifdef NORM_FTZ_EN
      send(24'h000100, 8'd10, 5'd15, 1'b0, mk(24'h000000, 8'd0, 1'b1, 1'b1), 1'b0);
      send(24'h100000, 8'd0, 5'd3, 1'b0, mk(24'h000000, 8'd0, 1'b1, 1'b1), 1'b0);
`else
      send(24'h000100, 8'd10, 5'd15, 1'b0, mk(24'h020000, 8'd0, 1'b1, 1'b0), 1'b0);
      send(24'h100000, 8'd0, 5'd3, 1'b0, mk(24'h100000, 8'd0, 1'b1, 1'b0), 1'b0);
`endif
      send(24'h000000, 8'd55, 5'd0, 1'b1, mk(24'h000000, 8'd0, 1'b0, 1'b1), 1'b0);
      send(24'h400000, 8'd1, 5'd1, 1'b0, model(24'h400000, 8'd1, 5'd1, 1'b0), 1'b0);
      send(24'h800000, 8'd255, 5'd0, 1'b0, mk(24'h800000, 8'd255, 1'b0, 1'b0), 1'b0);
      drain();

      // Backpressure: A,B fill the pipe, stall 3 cycles, then C,D stream in
      send(24'h80000A, 8'd10, 5'd0, 1'b0, mk(24'h80000A, 8'd10, 1'b0, 1'b0), 1'b0);
      send(24'h800014, 8'd20, 5'd0, 1'b0, mk(24'h800014, 8'd20, 1'b0, 1'b0), 1'b0);
      i_ready = 1'b0;
      i_mant = 24'h80001E; i_exp = 8'd30; i_lopd_pos = 5'd0; i_zero_flag = 1'b0; i_valid = 1'b1;
      hold_m = 24'h80000A;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_clk);
         chk("bp_ready_low", o_ready == 1'b0, 64'(o_ready), 64'd0);
         chk("bp_hold", o_valid && o_mant == hold_m && o_exp == 8'd10,
             64'({o_valid, o_mant, o_exp}), 64'({1'b1, hold_m, 8'd10}));
         @(posedge i_clk);
         #1;
      end
      i_ready = 1'b1;
      @(negedge i_clk);
      chk("bp_release", o_ready == 1'b1 && o_valid == 1'b1, 64'({o_ready, o_valid}), 64'd3);
      @(posedge i_clk);
      sb.push_back(mk(24'h80001E, 8'd30, 1'b0, 1'b0));
      #1;
      i_mant = 24'h800028; i_exp = 8'd40;
      @(negedge i_clk);
      chk("bp_nogap_b", o_valid == 1'b1 && o_ready == 1'b1, 64'({o_ready, o_valid}), 64'd3);
      @(posedge i_clk);
      sb.push_back(mk(24'h800028, 8'd40, 1'b0, 1'b0));
      #1;
      i_valid = 1'b0;
      @(negedge i_clk);
      chk("bp_nogap_c", o_valid == 1'b1, 64'(o_valid), 64'd1);
      @(negedge i_clk);
      chk("bp_nogap_d", o_valid == 1'b1, 64'(o_valid), 64'd1);
      drain();

      // Randomized beats against the reference model, random backpressure
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 19);
         e = ((r % 2) == 1) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255));
         if (r == 0) begin
            m = 24'd0; p = 5'($urandom_range(0, 31)); z = 1'b1;
         end else if (r == 1) begin
            m = 24'd1; p = 5'($urandom_range(24, 31)); z = 1'b0;
            n_illegal++;
            $display("note: illegal i_lopd_pos=%0d with nonzero mantissa, clamped to 23", p);
         end else begin
            p = 5'($urandom_range(0, 23));
            top = 24'h800000 >> p;
            m = (24'($urandom()) & (top - 24'd1)) | top;
            z = 1'b0;
         end
         ex = model(m, e, p, z);
         send(m, e, p, z, ex, 1'b1);
      end
      drain();

      // Reset with both stages full: in-flight beats vanish
      i_ready = 1'b0;
      send(24'h800000, 8'd77, 5'd0, 1'b0, mk(24'h800000, 8'd77, 1'b0, 1'b0), 1'b0);
      send(24'h800000, 8'd88, 5'd0, 1'b0, mk(24'h800000, 8'd88, 1'b0, 1'b0), 1'b0);
      chk("full_ready_low", o_ready == 1'b0, 64'(o_ready), 64'd0);
      i_rst = 1'b1;
      #1;
      chk("midrst_valid", o_valid == 1'b0, 64'(o_valid), 64'd0);
      chk("midrst_ready", o_ready == 1'b1, 64'(o_ready), 64'd1);
      sb.delete();
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      send(24'h400000, 8'd5, 5'd1, 1'b0, mk(24'h800000, 8'd4, 1'b0, 1'b0), 1'b0);
      drain();
      repeat (4) @(posedge i_clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
